// File: rtl/inert_seq_pkg.sv
// Shared types and constants for the inertial-interface transaction sequencer.
package inert_seq_pkg;

   // Sequencer states: power-up wait, config writes, then yaw low/high reads per INT
   typedef enum logic [2:0] {
      StWaitInit,
      StCfgWr,
      StCfgWt,
      StIdle,
      StRdL,
      StRdLWt,
      StRdH,
      StRdHWt
   } state_e;

   // Configuration writes, issued in table order after power-up
   localparam logic [15:0] CFG_INT = 16'h0D02;  // INT pin on gyro data-ready
   localparam logic [15:0] CFG_ODR = 16'h1160;  // gyro ODR 416 Hz
   localparam logic [15:0] CFG_RND = 16'h1440;  // register rounding

   // Read commands for yaw-rate output registers
   localparam logic [15:0] RD_YAWL = 16'hA600;
   localparam logic [15:0] RD_YAWH = 16'hA700;

   localparam logic [15:0] INIT_WAIT_DFLT = 16'hFFFF;
   localparam logic [11:0] TIMEOUT_DFLT   = 12'd2048;

   // Config table lookup by write index
   function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    cfg_cmd = CFG_INT;
         2'd1:    cfg_cmd = CFG_ODR;
         default: cfg_cmd = CFG_RND;
      endcase
   endfunction

endpackage

// File: rtl/inert_seq_sync2.sv
// Two-flop synchronizer (sync2) for the asynchronous sensor INT line.
module inert_seq_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1_q;
   logic ff2_q;

   // Shift the async input through two flops; both clear on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= d;
         ff2_q <= ff1_q;
      end
   end

   assign q = ff2_q;

endmodule

// File: rtl/inert_seq.sv
// Gyro transaction sequencer: power-up wait, three config writes, then a yaw
// low/high read pair per data-ready. Sole driver of the SPI monarch command port.
// Optional SPI watchdog: define INERT_SPI_WDOG_EN.
module inert_seq
   import inert_seq_pkg::*;
#(
   parameter logic [15:0] INIT_WAIT = INIT_WAIT_DFLT
`ifdef INERT_SPI_WDOG_EN
   ,
   parameter logic [11:0] TIMEOUT   = TIMEOUT_DFLT
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        spi_done,
   input  logic [7:0]  spi_rd_data,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   output logic [15:0] yaw_rt,
   output logic        vld,
   output logic        init_done,
   output logic        err
);

   logic int_ff2;

   inert_seq_sync2 u_sync2 (
      .clk (clk),
      .rst (rst),
      .d   (INT),
      .q   (int_ff2)
   );

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [1:0]  idx_q, idx_d;
   logic        wrt_q, wrt_d;
   logic [15:0] cmd_q, cmd_d;
   logic [7:0]  low_q, low_d;
   logic [15:0] yaw_q, yaw_d;
   logic        vld_q, vld_d;
   logic        init_q, init_d;
`ifdef INERT_SPI_WDOG_EN
   logic [11:0] wd_q, wd_d;
   logic        err_q, err_d;
`endif

   // Next-state and registered-output logic; pulses default low every cycle
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      wrt_d   = 1'b0;
      cmd_d   = cmd_q;
      low_d   = low_q;
      yaw_d   = yaw_q;
      vld_d   = 1'b0;
      init_d  = init_q;
`ifdef INERT_SPI_WDOG_EN
      wd_d    = wd_q;
      err_d   = 1'b0;
`endif
      unique case (state_q)
         StWaitInit: begin
            if (timer_q == INIT_WAIT) begin
               state_d = StCfgWr;
               idx_d   = 2'd0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         StCfgWr: begin
            wrt_d   = 1'b1;
            cmd_d   = cfg_cmd(idx_q);
            state_d = StCfgWt;
         end
         StCfgWt: begin
            if (spi_done) begin
               if (idx_q == 2'd2) begin
                  init_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StCfgWr;
               end
            end
         end
         StIdle: begin
            if (int_ff2) state_d = StRdL;
         end
         StRdL: begin
            wrt_d   = 1'b1;
            cmd_d   = RD_YAWL;
            state_d = StRdLWt;
         end
         StRdLWt: begin
            if (spi_done) begin
               low_d   = spi_rd_data;
               state_d = StRdH;
            end
         end
         StRdH: begin
            wrt_d   = 1'b1;
            cmd_d   = RD_YAWH;
            state_d = StRdHWt;
         end
         StRdHWt: begin
            if (spi_done) begin
               yaw_d   = {spi_rd_data, low_q};
               vld_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StWaitInit;
      endcase
`ifdef INERT_SPI_WDOG_EN
      // Counter restarts with each transaction; a stalled wait abandons the transaction
      if (wrt_d) begin
         wd_d = 12'd0;
      end else if (state_q inside {StCfgWt, StRdLWt, StRdHWt}) begin
         if (!spi_done && (wd_q == TIMEOUT - 12'd1)) begin
            err_d   = 1'b1;
            state_d = init_q ? StIdle : StCfgWr;
         end else begin
            wd_d = wd_q + 12'd1;
         end
      end
`endif
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWaitInit;
         timer_q <= 16'd0;
         idx_q   <= 2'd0;
         wrt_q   <= 1'b0;
         cmd_q   <= 16'd0;
         low_q   <= 8'd0;
         yaw_q   <= 16'd0;
         vld_q   <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         wrt_q   <= wrt_d;
         cmd_q   <= cmd_d;
         low_q   <= low_d;
         yaw_q   <= yaw_d;
         vld_q   <= vld_d;
         init_q  <= init_d;
      end
   end

`ifdef INERT_SPI_WDOG_EN
   // Watchdog counter and error pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= 12'd0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign spi_wrt   = wrt_q;
   assign spi_cmd   = cmd_q;
   assign yaw_rt    = yaw_q;
   assign vld       = vld_q;
   assign init_done = init_q;

endmodule

// File: doc/inert_seq.md
# inert_seq

Transaction sequencer between the inertial-interface datapath and the SPI monarch that talks to the iNEMO gyro. After reset it waits for sensor power-up, issues the fixed configuration writes, then on every sensor data-ready (INT) reads yaw-rate low and high bytes. It presents a signed 16-bit yaw rate with a one-cycle valid strobe to the heading integrator. It is the sole owner of the SPI monarch's command port.

## Interface
- INIT_WAIT, 16'hFFFF: cycles from reset release to the first configuration write.
- TIMEOUT, 12'd2048: cycles allowed between spi_wrt and spi_done (used only with watchdog compiled in).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- INT  in  1  sensor data-ready, asynchronous; double-flopped internally
- spi_done  in  1  one-cycle pulse from SPI monarch at end of transaction
- spi_rd_data  in  8  low byte of returned SPI word, valid when spi_done=1
- spi_wrt  out  1  one-cycle transaction start to SPI monarch
- spi_cmd  out  16  command word; stable from spi_wrt until spi_done
- yaw_rt  out  16  signed yaw rate {high,low}; held between updates
- vld  out  1  one-cycle strobe, yaw_rt updated
- init_done  out  1  high once all configuration writes complete; sticky until reset
- err  out  1  one-cycle pulse on SPI timeout

## Operation
- States: WAIT_INIT, CFG_WR, CFG_WT, IDLE, RD_L, RD_L_WT, RD_H, RD_H_WT.
- WAIT_INIT: 16-bit timer counts up from 0; when timer == INIT_WAIT go to CFG_WR, index 0.
- Config table (index 0..2): 16'h0D02 (INT on data-ready), 16'h1160 (gyro ODR 416 Hz), 16'h1440 (rounding).
- CFG_WR: pulse spi_wrt with spi_cmd = table[index]; go CFG_WT. CFG_WT: on spi_done, index++; if index was 2 set init_done, go IDLE; else CFG_WR.
- IDLE: if INT_ff2 = 1 go RD_L. INT is level-sensed; sensor drops INT after yaw-high read.
- RD_L: spi_wrt, spi_cmd = 16'hA600; RD_L_WT: on spi_done latch spi_rd_data into low register, go RD_H.
- RD_H: spi_wrt, spi_cmd = 16'hA700; RD_H_WT: on spi_done, yaw_rt <= {spi_rd_data, low}, vld = 1, go IDLE.
- INT edges during RD_* are ignored; no queueing.
- spi_done outside a *_WT state is ignored.
- Reset (any state, any cycle): state WAIT_INIT, timer 0, index 0; spi_wrt, vld, err, init_done = 0; yaw_rt = 0; spi_cmd = 0; INT synchronizer flops = 0. An in-flight SPI transaction is abandoned.

## Timing
- spi_wrt asserts the cycle after entering CFG_WR/RD_L/RD_H (registered), exactly one cycle.
- spi_cmd changes only in the cycle spi_wrt asserts.
- INT to RD_L entry: 2-cycle synchronizer plus 1 cycle; spi_wrt for yaw-low at cycle 4 after INT rises (sampled at clk).
- vld and new yaw_rt appear the cycle after spi_done of the yaw-high read.
- First config write: spi_wrt at cycle INIT_WAIT+2 after rst deasserts.
- init_done rises the cycle after the third config spi_done.

## Configuration
- INERT_SPI_WDOG_EN defined: counter resets on each spi_wrt, counts in *_WT states; at TIMEOUT without spi_done, pulse err, and go to CFG_WR (same index) if init_done=0, else IDLE; partial yaw data discarded, no vld.
- Not defined: no counter; *_WT states wait indefinitely; err tied 0.

## Structure
- Package inert_seq_pkg: state enum, config table constants (CFG_INT, CFG_ODR, CFG_RND), read commands (RD_YAWL, RD_YAWH), default INIT_WAIT/TIMEOUT.
- Sub-module sync2: two-flop synchronizer for INT, sync reset to 0.

## Test plan
- Reset release, INIT_WAIT=16 -> spi_wrt at cycle 18 with spi_cmd 16'h0D02, then 16'h1160, 16'h1440; init_done high after third spi_done.
- INT high, model returns low 8'h34 then high 8'hF2 -> spi_cmds 16'hA600, 16'hA700; vld one cycle; yaw_rt = 16'hF234 (-3532).
- INT toggled high during RD_H_WT -> no extra transaction until IDLE; if INT still high then, new read starts.
- rst asserted during CFG_WT index 1 -> all outputs 0; sequence restarts from WAIT_INIT and 16'h0D02.
- Watchdog enabled, TIMEOUT=64, spi_done withheld on RD_L -> err pulse at cycle 64 after spi_wrt, return to IDLE, no vld.
- Spurious spi_done in IDLE -> no state change, no vld.
